// File: rtl/bram_arb_pkg.sv
// Shared types and constants for the two-requester BRAM access arbiter.
package bram_arb_pkg;

  localparam int NUM_REQ     = 2;
  localparam int STATS_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } arb_state_t;

  // Saturating increment for the optional statistics counters.
  function automatic logic [STATS_WIDTH-1:0] sat_inc(input logic [STATS_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin pick with a registered last-grant pointer; the pointer
// only moves when the caller commits a grant.
module rr_arbiter_2
  import bram_arb_pkg::*;
(
  input  logic               sys_clk_in,
  input  logic               sys_rst_n_in,
  input  logic [NUM_REQ-1:0] req,
  input  logic               grant_en,
  output logic               grant_idx
);

  logic last_grant;

  // On a tie the requester that did not win last time goes next.
  always_comb begin
    grant_idx = req[1];
    if (&req) grant_idx = ~last_grant;
  end

  // Reset value 1 lets requester 0 win the first tie.
  always_ff @(posedge sys_clk_in or negedge sys_rst_n_in) begin
    if (!sys_rst_n_in)  last_grant <= 1'b1;
    else if (grant_en)  last_grant <= grant_idx;
  end

endmodule

// File: rtl/bram_access_arbiter.sv
// Shares one BRAM port between two requesters, one access per grant.
// Optional statistics counters are built when BRAM_ARB_STATS_EN is defined.
module bram_access_arbiter
  import bram_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 13,
  parameter int READ_LATENCY = 2
) (
  input  logic                          sys_clk_in,
  input  logic                          sys_rst_n_in,
`ifdef BRAM_ARB_STATS_EN
  input  logic                          stats_clr_in,
  output logic [STATS_WIDTH-1:0]        grant_cnt0_out,
  output logic [STATS_WIDTH-1:0]        grant_cnt1_out,
  output logic [STATS_WIDTH-1:0]        conflict_cnt_out,
`endif
  input  logic [NUM_REQ-1:0]            req_in,
  input  logic [NUM_REQ-1:0]            req_wen_in,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_in,
  output logic [NUM_REQ-1:0]            req_ack_out,
  output logic [NUM_REQ-1:0]            req_rvalid_out,
  output logic [DATA_WIDTH-1:0]         req_rdata_out,
  output logic [ADDR_WIDTH-1:0]         addr_out,
  output logic [DATA_WIDTH-1:0]         wdata_out,
  output logic                          wen_out,
  output logic                          en_out,
  input  logic [DATA_WIDTH-1:0]         rdata_in,
  output arb_state_t                    state_dbg_out
);

  // Handshake: a requester holds req_in[i] and its fields stable until it sees
  // req_ack_out[i] (access issued), then drops req the following cycle; read
  // data arrives later as a one-cycle req_rvalid_out[i] with req_rdata_out.
  localparam logic [3:0] RL_CNT = 4'(READ_LATENCY);

  arb_state_t                state, state_nxt;
  logic [3:0]                cnt, cnt_nxt, cnt_inc;
  logic                      win, win_nxt;
  logic                      op_wen, op_wen_nxt;
  logic                      grant_en, grant_idx;
  logic [NUM_REQ-1:0]        ack_nxt, rvalid_nxt;
  logic [DATA_WIDTH-1:0]     rdata_nxt, wdata_nxt;
  logic [ADDR_WIDTH-1:0]     addr_nxt;
  logic                      en_nxt, wen_nxt;

  rr_arbiter_2 u_rr (
    .sys_clk_in   (sys_clk_in),
    .sys_rst_n_in (sys_rst_n_in),
    .req          (req_in),
    .grant_en     (grant_en),
    .grant_idx    (grant_idx)
  );

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    cnt_inc    = cnt + 4'd1;
    win_nxt    = win;
    op_wen_nxt = op_wen;
    addr_nxt   = addr_out;
    wdata_nxt  = wdata_out;
    rdata_nxt  = req_rdata_out;
    en_nxt     = 1'b0;
    wen_nxt    = 1'b0;
    ack_nxt    = '0;
    rvalid_nxt = '0;
    grant_en   = 1'b0;
    case (state)
      IDLE: begin
        if (|req_in) begin
          grant_en   = 1'b1;
          win_nxt    = grant_idx;
          op_wen_nxt = req_wen_in[grant_idx];
          addr_nxt   = grant_idx ? req_addr_in[ADDR_WIDTH +: ADDR_WIDTH]
                                 : req_addr_in[0 +: ADDR_WIDTH];
          wdata_nxt  = grant_idx ? req_wdata_in[DATA_WIDTH +: DATA_WIDTH]
                                 : req_wdata_in[0 +: DATA_WIDTH];
          en_nxt     = 1'b1;
          wen_nxt    = req_wen_in[grant_idx];
          ack_nxt[grant_idx] = 1'b1;
          state_nxt  = ISSUE;
        end
      end
      ISSUE: begin
        if (op_wen) begin
          state_nxt = IDLE;
        end else begin
          // The counter reaches 1 on leaving ISSUE; a latency of 1 captures here.
          cnt_nxt = 4'd1;
          if (RL_CNT == 4'd1) begin
            rdata_nxt       = rdata_in;
            rvalid_nxt[win] = 1'b1;
            state_nxt       = IDLE;
          end else begin
            state_nxt = WAIT_RD;
          end
        end
      end
      WAIT_RD: begin
        cnt_nxt = cnt_inc;
        if (cnt_inc == RL_CNT) begin
          rdata_nxt       = rdata_in;
          rvalid_nxt[win] = 1'b1;
          state_nxt       = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_in or negedge sys_rst_n_in) begin
    if (!sys_rst_n_in) begin
      state          <= IDLE;
      cnt            <= '0;
      win            <= 1'b0;
      op_wen         <= 1'b0;
      req_ack_out    <= '0;
      req_rvalid_out <= '0;
      req_rdata_out  <= '0;
      addr_out       <= '0;
      wdata_out      <= '0;
      wen_out        <= 1'b0;
      en_out         <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      win            <= win_nxt;
      op_wen         <= op_wen_nxt;
      req_ack_out    <= ack_nxt;
      req_rvalid_out <= rvalid_nxt;
      req_rdata_out  <= rdata_nxt;
      addr_out       <= addr_nxt;
      wdata_out      <= wdata_nxt;
      wen_out        <= wen_nxt;
      en_out         <= en_nxt;
    end
  end

  assign state_dbg_out = state;

`ifdef BRAM_ARB_STATS_EN
  logic conflict;
  assign conflict = (state == IDLE) && (&req_in);

  always_ff @(posedge sys_clk_in or negedge sys_rst_n_in) begin
    if (!sys_rst_n_in) begin
      grant_cnt0_out   <= '0;
      grant_cnt1_out   <= '0;
      conflict_cnt_out <= '0;
    end else if (stats_clr_in) begin
      grant_cnt0_out   <= '0;
      grant_cnt1_out   <= '0;
      conflict_cnt_out <= '0;
    end else begin
      if (grant_en && !grant_idx) grant_cnt0_out   <= sat_inc(grant_cnt0_out);
      if (grant_en &&  grant_idx) grant_cnt1_out   <= sat_inc(grant_cnt1_out);
      if (conflict)               conflict_cnt_out <= sat_inc(conflict_cnt_out);
    end
  end
`endif

endmodule

// File: tb/tb_bram_access_arbiter.sv
// Self-checking bench for bram_access_arbiter: directed scenarios plus random
// two-requester traffic checked against a transaction-level reference model.
module tb_bram_access_arbiter;
  import bram_arb_pkg::*;

  localparam int DW = 8;
  localparam int AW = 13;
  localparam int RL = 2;

  logic              sys_clk_in, sys_rst_n_in;
  logic [1:0]        req_in, req_wen_in;
  logic [2*AW-1:0]   req_addr_in;
  logic [2*DW-1:0]   req_wdata_in;
  logic [1:0]        req_ack_out, req_rvalid_out;
  logic [DW-1:0]     req_rdata_out, wdata_out, rdata_in;
  logic [AW-1:0]     addr_out;
  logic              wen_out, en_out;
  arb_state_t        state_dbg_out;
`ifdef BRAM_ARB_STATS_EN
  logic              stats_clr_in;
  logic [15:0]       grant_cnt0_out, grant_cnt1_out, conflict_cnt_out;
`endif

  int vectors;
  int miscompares;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  bram_access_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(RL)) dut (
    .sys_clk_in       (sys_clk_in),
    .sys_rst_n_in     (sys_rst_n_in),
`ifdef BRAM_ARB_STATS_EN
    .stats_clr_in     (stats_clr_in),
    .grant_cnt0_out   (grant_cnt0_out),
    .grant_cnt1_out   (grant_cnt1_out),
    .conflict_cnt_out (conflict_cnt_out),
`endif
    .req_in           (req_in),
    .req_wen_in       (req_wen_in),
    .req_addr_in      (req_addr_in),
    .req_wdata_in     (req_wdata_in),
    .req_ack_out      (req_ack_out),
    .req_rvalid_out   (req_rvalid_out),
    .req_rdata_out    (req_rdata_out),
    .addr_out         (addr_out),
    .wdata_out        (wdata_out),
    .wen_out          (wen_out),
    .en_out           (en_out),
    .rdata_in         (rdata_in),
    .state_dbg_out    (state_dbg_out)
  );

  // ---------------- clock / reset ----------------
  initial begin
    sys_clk_in = 1'b0;
    forever #5 sys_clk_in = ~sys_clk_in;
  end

  // BRAM model: registered read, data presented for one cycle after the en
  // cycle and random garbage otherwise, so a mistimed capture is visible.
  always @(posedge sys_clk_in) begin
    if (en_out && wen_out) mem[addr_out] <= wdata_out;
    if (en_out && !wen_out) rdata_in <= mem[addr_out];
    else                    rdata_in <= DW'($urandom);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge sys_clk_in);
    #1;
  endtask

  task automatic drive_req(input int i, input logic on, input logic wen,
                           input logic [AW-1:0] addr, input logic [DW-1:0] data);
    req_in[i]                 = on;
    req_wen_in[i]             = wen;
    req_addr_in[i*AW +: AW]   = addr;
    req_wdata_in[i*DW +: DW]  = data;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    sys_rst_n_in = 1'b0;
    req_in = '0; req_wen_in = '0; req_addr_in = '0; req_wdata_in = '0;
`ifdef BRAM_ARB_STATS_EN
    stats_clr_in = 1'b0;
`endif
    repeat (3) @(posedge sys_clk_in);
    #1;
    vectors++;
    if ({en_out, wen_out, req_ack_out, req_rvalid_out} !== 6'b0) begin
      miscompares++; $display("FAIL reset_strobes: got %b expected 000000", {en_out, wen_out, req_ack_out, req_rvalid_out});
    end
    vectors++;
    if ({addr_out, wdata_out, req_rdata_out} !== '0) begin
      miscompares++; $display("FAIL reset_data: got %h/%h/%h expected 0/0/0", addr_out, wdata_out, req_rdata_out);
    end
    vectors++;
    if (state_dbg_out !== IDLE) begin
      miscompares++; $display("FAIL reset_state: got %0d expected %0d", state_dbg_out, IDLE);
    end
    sys_rst_n_in = 1'b1;
    tick();
    vectors++;
    if ({en_out, req_ack_out} !== 3'b0) begin
      miscompares++; $display("FAIL idle_no_req: got %b expected 000", {en_out, req_ack_out});
    end
  endtask

  task automatic test_write();
    drive_req(0, 1'b1, 1'b1, 13'h0010, 8'hA5);
    tick();
    vectors++;
    if ({req_ack_out, en_out, wen_out} !== 4'b0111) begin
      miscompares++; $display("FAIL write_issue: got %b expected 0111", {req_ack_out, en_out, wen_out});
    end
    vectors++;
    if ({addr_out, wdata_out} !== {13'h0010, 8'hA5}) begin
      miscompares++; $display("FAIL write_bus: got %h/%h expected 0010/a5", addr_out, wdata_out);
    end
    drive_req(0, 1'b0, 1'b0, 13'h0, 8'h0);
    tick();
    vectors++;
    if ({req_ack_out, en_out, wen_out} !== 4'b0000) begin
      miscompares++; $display("FAIL write_one_cycle: got %b expected 0000", {req_ack_out, en_out, wen_out});
    end
    vectors++;
    if (addr_out !== 13'h0010) begin
      miscompares++; $display("FAIL write_addr_hold: got %h expected 0010", addr_out);
    end
  endtask

  task automatic test_read();
    drive_req(1, 1'b1, 1'b0, 13'h0010, 8'h00);
    tick();
    vectors++;
    if ({req_ack_out, en_out, wen_out} !== 4'b1010) begin
      miscompares++; $display("FAIL read_issue: got %b expected 1010", {req_ack_out, en_out, wen_out});
    end
    drive_req(1, 1'b0, 1'b0, 13'h0, 8'h0);
    tick();
    vectors++;
    if ({req_rvalid_out, en_out, wen_out} !== 4'b0000) begin
      miscompares++; $display("FAIL read_wait: got %b expected 0000", {req_rvalid_out, en_out, wen_out});
    end
    tick();
    vectors++;
    if (req_rvalid_out !== 2'b10 || req_rdata_out !== 8'hA5) begin
      miscompares++; $display("FAIL read_data: got rvalid=%b data=%h expected rvalid=10 data=a5", req_rvalid_out, req_rdata_out);
    end
    tick();
    vectors++;
    if (req_rvalid_out !== 2'b00) begin
      miscompares++; $display("FAIL read_rvalid_pulse: got %b expected 00", req_rvalid_out);
    end
  endtask

  task automatic test_fairness();
    int order [6];
    int grants;
    grants = 0;
    drive_req(0, 1'b1, 1'b1, 13'h0020, 8'h11);
    drive_req(1, 1'b1, 1'b1, 13'h0021, 8'h22);
    for (int c = 0; c < 40 && grants < 6; c++) begin
      tick();
      vectors++;
      if (req_ack_out === 2'b11) begin
        miscompares++; $display("FAIL fair_onehot: got %b expected one-hot", req_ack_out);
      end
      if (req_ack_out !== 2'b00) begin
        order[grants] = req_ack_out[1] ? 1 : 0;
        grants++;
        if (grants == 6) req_in = 2'b00;
      end
    end
    req_in = 2'b00;
    vectors++;
    if (grants != 6) begin
      miscompares++; $display("FAIL fair_grant_count: got %0d expected 6", grants);
    end
    for (int k = 0; k < grants; k++) begin
      vectors++;
      if (order[k] != k % 2) begin
        miscompares++; $display("FAIL fair_order[%0d]: got %0d expected %0d", k, order[k], k % 2);
      end
    end
    tick();
`ifdef BRAM_ARB_STATS_EN
    vectors++;
    if (conflict_cnt_out !== 16'd6) begin
      miscompares++; $display("FAIL stats_conflict: got %0d expected 6", conflict_cnt_out);
    end
    vectors++;
    if (grant_cnt0_out !== 16'd4 || grant_cnt1_out !== 16'd4) begin
      miscompares++; $display("FAIL stats_grants: got %0d/%0d expected 4/4", grant_cnt0_out, grant_cnt1_out);
    end
`endif
  endtask

  task automatic test_drop_before_ack();
    drive_req(1, 1'b1, 1'b0, 13'h0010, 8'h00);
    tick();
    vectors++;
    if (req_ack_out !== 2'b10) begin
      miscompares++; $display("FAIL drop_first_ack: got %b expected 10", req_ack_out);
    end
    req_in[1] = 1'b0;
    drive_req(0, 1'b1, 1'b1, 13'h0040, 8'h77);
    tick();
    req_in[0] = 1'b0;
    vectors++;
    if (req_ack_out !== 2'b00) begin
      miscompares++; $display("FAIL drop_wait_ack: got %b expected 00", req_ack_out);
    end
    tick();
    vectors++;
    if (req_rvalid_out !== 2'b10 || req_rdata_out !== 8'hA5) begin
      miscompares++; $display("FAIL drop_read_data: got %b/%h expected 10/a5", req_rvalid_out, req_rdata_out);
    end
    drive_req(1, 1'b1, 1'b1, 13'h0041, 8'h55);
    tick();
    vectors++;
    if (req_ack_out !== 2'b10 || addr_out !== 13'h0041) begin
      miscompares++; $display("FAIL drop_second_ack: got %b/%h expected 10/0041", req_ack_out, addr_out);
    end
    req_in[1] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      vectors++;
      if (req_ack_out !== 2'b00) begin
        miscompares++; $display("FAIL drop_no_ack0: cycle %0d got %b expected 00", c, req_ack_out);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    drive_req(0, 1'b1, 1'b0, 13'h0010, 8'h00);
    tick();
    vectors++;
    if (req_ack_out !== 2'b01) begin
      miscompares++; $display("FAIL rst_pre_ack: got %b expected 01", req_ack_out);
    end
    req_in[0] = 1'b0;
    tick();
    #2 sys_rst_n_in = 1'b0;
    #1;
    vectors++;
    if ({en_out, wen_out, req_ack_out, req_rvalid_out} !== 6'b0 ||
        {addr_out, wdata_out, req_rdata_out} !== '0) begin
      miscompares++; $display("FAIL rst_mid_read: got %b %h/%h/%h expected all zero",
        {en_out, wen_out, req_ack_out, req_rvalid_out}, addr_out, wdata_out, req_rdata_out);
    end
    @(posedge sys_clk_in);
    @(negedge sys_clk_in);
    sys_rst_n_in = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      vectors++;
      if ({req_ack_out, req_rvalid_out} !== 4'b0) begin
        miscompares++; $display("FAIL rst_no_rvalid: cycle %0d got %b expected 0000", c, {req_ack_out, req_rvalid_out});
      end
    end
    drive_req(0, 1'b1, 1'b1, 13'h0030, 8'h33);
    drive_req(1, 1'b1, 1'b1, 13'h0031, 8'h44);
    tick();
    req_in = 2'b00;
    vectors++;
    if (req_ack_out !== 2'b01) begin
      miscompares++; $display("FAIL rst_first_tie: got %b expected 01", req_ack_out);
    end
    tick();
  endtask

`ifdef BRAM_ARB_STATS_EN
  task automatic test_stats_clear();
    stats_clr_in = 1'b1;
    drive_req(0, 1'b1, 1'b1, 13'h0050, 8'h66);
    tick();
    req_in[0] = 1'b0;
    tick();
    vectors++;
    if ({grant_cnt0_out, grant_cnt1_out, conflict_cnt_out} !== '0) begin
      miscompares++; $display("FAIL stats_clear: got %0d/%0d/%0d expected 0/0/0", grant_cnt0_out, grant_cnt1_out, conflict_cnt_out);
    end
    stats_clr_in = 1'b0;
    drive_req(0, 1'b1, 1'b1, 13'h0051, 8'h67);
    tick();
    req_in[0] = 1'b0;
    tick();
    vectors++;
    if (grant_cnt0_out !== 16'd1) begin
      miscompares++; $display("FAIL stats_after_clear: got %0d expected 1", grant_cnt0_out);
    end
  endtask
`endif

  // ---------------- random traffic vs. reference model ----------------
  typedef struct {
    int            cyc;
    logic [1:0]    ack;
    logic [1:0]    rvalid;
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } ev_t;

  task automatic test_random();
    logic [DW-1:0] ref_mem [0:31];
    logic [DW-1:0] exp_q [$];
    ev_t           ev_q [$];
    ev_t           e;
    logic [1:0]    prev_ack, exp_ack, exp_rv;
    logic          exp_wen;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata, exp_rdata;
    logic          act [2];
    int            gap [2];
    int            next_arb, last_g, w;
    logic [AW-1:0] a;

    // Preload: requester 0 writes every model address with a known value.
    for (int k = 0; k < 32; k++) begin
      ref_mem[k] = DW'($urandom);
      drive_req(0, 1'b1, 1'b1, AW'(k), ref_mem[k]);
      tick();
      req_in[0] = 1'b0;
      vectors++;
      if (req_ack_out !== 2'b01 || addr_out !== AW'(k)) begin
        miscompares++; $display("FAIL preload[%0d]: got %b/%h expected 01/%h", k, req_ack_out, addr_out, AW'(k));
      end
      tick();
    end

    last_g   = 0;
    next_arb = 0;
    exp_addr = 13'd31;
    prev_ack = 2'b00;
    act[0] = 1'b0; act[1] = 1'b0;
    gap[0] = 0;    gap[1] = 0;

    for (int cyc = 0; cyc < 500; cyc++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        if (prev_ack[i]) begin
          act[i] = 1'b0; req_in[i] = 1'b0; gap[i] = $urandom_range(0, 2);
        end else if (act[i] && $urandom_range(0, 15) == 0) begin
          act[i] = 1'b0; req_in[i] = 1'b0;
        end else if (!act[i]) begin
          if (gap[i] > 0) gap[i]--;
          else if (cyc < 480 && $urandom_range(0, 1) == 1) begin
            act[i] = 1'b1;
            drive_req(i, 1'b1, 1'($urandom), AW'($urandom_range(0, 31)), DW'($urandom));
          end
        end
      end

      exp_ack = 2'b00; exp_rv = 2'b00; exp_wen = 1'b0; exp_wdata = '0;
      if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
        e = ev_q.pop_front();
        exp_ack = e.ack; exp_rv = e.rvalid; exp_wen = e.wen; exp_wdata = e.wdata;
        if (e.ack != 2'b00) exp_addr = e.addr;
      end
      vectors++;
      if ({req_ack_out, req_rvalid_out, en_out, wen_out} !== {exp_ack, exp_rv, |exp_ack, exp_wen}) begin
        miscompares++; $display("FAIL rand_strobes cyc %0d: got ack=%b rv=%b en=%b wen=%b expected ack=%b rv=%b en=%b wen=%b",
          cyc, req_ack_out, req_rvalid_out, en_out, wen_out, exp_ack, exp_rv, |exp_ack, exp_wen);
      end
      vectors++;
      if (addr_out !== exp_addr) begin
        miscompares++; $display("FAIL rand_addr cyc %0d: got %h expected %h", cyc, addr_out, exp_addr);
      end
      if (exp_ack != 2'b00 && exp_wen) begin
        vectors++;
        if (wdata_out !== exp_wdata) begin
          miscompares++; $display("FAIL rand_wdata cyc %0d: got %h expected %h", cyc, wdata_out, exp_wdata);
        end
      end
      if (exp_rv != 2'b00 && exp_q.size() > 0) begin
        exp_rdata = exp_q.pop_front();
        vectors++;
        if (req_rdata_out !== exp_rdata) begin
          miscompares++; $display("FAIL rand_rdata cyc %0d: got %h expected %h", cyc, req_rdata_out, exp_rdata);
        end
      end
      prev_ack = req_ack_out;

      // Model: one access per grant, alternate on a tie, busy 2 cycles per
      // write and 1+READ_LATENCY cycles per read.
      if (cyc >= next_arb && req_in != 2'b00) begin
        if (req_in == 2'b11) w = (last_g == 0) ? 1 : 0;
        else                 w = req_in[1] ? 1 : 0;
        last_g  = w;
        a       = req_addr_in[w*AW +: AW];
        e.cyc   = cyc + 1;
        e.ack   = 2'b01 << w;
        e.rvalid = 2'b00;
        e.wen   = req_wen_in[w];
        e.addr  = a;
        e.wdata = req_wdata_in[w*DW +: DW];
        ev_q.push_back(e);
        if (req_wen_in[w]) begin
          ref_mem[a[4:0]] = e.wdata;
          next_arb = cyc + 2;
        end else begin
          exp_q.push_back(ref_mem[a[4:0]]);
          e.cyc    = cyc + 1 + RL;
          e.ack    = 2'b00;
          e.rvalid = 2'b01 << w;
          e.wen    = 1'b0;
          ev_q.push_back(e);
          next_arb = cyc + 1 + RL;
        end
      end
    end
    req_in = 2'b00;
    vectors++;
    if (ev_q.size() != 0 || exp_q.size() != 0) begin
      miscompares++; $display("FAIL rand_drain: got %0d/%0d pending expected 0/0", ev_q.size(), exp_q.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_write();
    test_read();
    test_fairness();
    test_drop_before_ack();
    test_reset_mid_read();
`ifdef BRAM_ARB_STATS_EN
    test_stats_clear();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
